// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU request scheduler.
package alu_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [1:0] INP_BOTH   = 2'b11;
  localparam logic [1:0] INP_NONE   = 2'b00;

  localparam logic [3:0] CMD_MUL    = 4'h9;
  localparam logic [3:0] CMD_SHLSUB = 4'hA;

  // Bit positions inside rsp_flags = {err, l, e, g, oflow, cout}
  localparam int unsigned F_COUT  = 0;
  localparam int unsigned F_OFLOW = 1;
  localparam int unsigned F_G     = 2;
  localparam int unsigned F_E     = 3;
  localparam int unsigned F_L     = 4;
  localparam int unsigned F_ERR   = 5;
  localparam int unsigned NFLAGS  = 6;

endpackage

// File: rtl/alu_req_sched_rr_arbiter.sv
// Round-robin arbiter: combinational pick starting at the pointer, pointer
// advances past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  id
);

  logic [IDW-1:0] ptr;
  logic           found;
  int unsigned    idx;

  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (32'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        id         = IDW'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= IDW'((32'(id) + 1) % NREQ);
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// Shares one ALU between NREQ requesters: grant, issue, wait for the
// command latency, capture result/flags and hand them back with the id.
module alu_req_sched
  import alu_sched_pkg::*;
#(
  parameter int unsigned DW      = 8,
  parameter int unsigned CW      = 4,
  parameter int unsigned NREQ    = 4,
  parameter int unsigned IDW     = 2,
  parameter int unsigned LAT     = 2,
  parameter int unsigned LAT_MUL = 3
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*DW-1:0] req_opa,
  input  logic [NREQ*DW-1:0] req_opb,
  input  logic [NREQ*CW-1:0] req_cmd,
  input  logic [NREQ-1:0]    req_mode,
  input  logic [NREQ-1:0]    req_cin,
  output logic [1:0]         alu_inp_valid,
  output logic [DW-1:0]      alu_opa,
  output logic [DW-1:0]      alu_opb,
  output logic [CW-1:0]      alu_cmd,
  output logic               alu_mode,
  output logic               alu_cin,
  output logic               alu_ce,
  input  logic [2*DW-1:0]    alu_res,
  input  logic               alu_cout,
  input  logic               alu_oflow,
  input  logic               alu_g,
  input  logic               alu_e,
  input  logic               alu_l,
  input  logic               alu_err,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [IDW-1:0]     rsp_id,
  output logic [2*DW-1:0]    rsp_res,
  output logic [NFLAGS-1:0]  rsp_flags,
  output logic               busy
);

  localparam int unsigned CNTW = $clog2(LAT + LAT_MUL + 1);

  state_t              state, state_nxt;
  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      gid;
  logic [IDW-1:0]      id_q;
  logic [DW-1:0]       opa_q, opb_q;
  logic [CW-1:0]       cmd_q;
  logic                mode_q, cin_q;
  logic [CNTW-1:0]     cnt;
  logic [2*DW-1:0]     res_q, res_clean;
  logic [NFLAGS-1:0]   flags_q, flags_clean;
  logic                long_op;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .clk   (CLK),
    .rst_n (RST),
    .req   (req_valid),
    .en    (state == S_IDLE),
    .grant (grant),
    .id    (gid)
  );

  assign long_op = mode_q && ((cmd_q == CMD_MUL) || (cmd_q == CMD_SHLSUB));

  // Undriven (z) or unknown ALU outputs are captured as 0.
  always_comb begin
    res_clean   = '0;
    flags_clean = '0;
    for (int unsigned i = 0; i < 2*DW; i++) res_clean[i] = (alu_res[i] === 1'b1);
    flags_clean[F_COUT]  = (alu_cout  === 1'b1);
    flags_clean[F_OFLOW] = (alu_oflow === 1'b1);
    flags_clean[F_G]     = (alu_g     === 1'b1);
    flags_clean[F_E]     = (alu_e     === 1'b1);
    flags_clean[F_L]     = (alu_l     === 1'b1);
    flags_clean[F_ERR]   = (alu_err   === 1'b1);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (|req_valid) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cnt == '0) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready     = '0;
    alu_inp_valid = INP_NONE;
    alu_ce        = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      S_IDLE:  req_ready = grant;
      S_ISSUE: begin
        alu_inp_valid = INP_BOTH;
        alu_ce        = 1'b1;
      end
      S_WAIT:  alu_ce = 1'b1;
      S_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      id_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      cmd_q   <= '0;
      mode_q  <= 1'b0;
      cin_q   <= 1'b0;
      cnt     <= '0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: if (|req_valid) begin
          id_q   <= gid;
          opa_q  <= req_opa[gid*DW +: DW];
          opb_q  <= req_opb[gid*DW +: DW];
          cmd_q  <= req_cmd[gid*CW +: CW];
          mode_q <= req_mode[gid];
          cin_q  <= req_cin[gid];
        end
        S_ISSUE: cnt <= long_op ? CNTW'(LAT_MUL - 1) : CNTW'(LAT - 1);
        S_WAIT: begin
          if (cnt == '0) begin
            res_q   <= res_clean;
            flags_q <= flags_clean;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign alu_opa   = opa_q;
  assign alu_opb   = opb_q;
  assign alu_cmd   = cmd_q;
  assign alu_mode  = mode_q;
  assign alu_cin   = cin_q;
  assign rsp_id    = id_q;
  assign rsp_res   = res_q;
  assign rsp_flags = flags_q;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_alu_req_sched.sv
// Bench for alu_req_sched: a stand-in ALU, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_alu_req_sched;

  localparam int unsigned DW = 8, CW = 4, NREQ = 4, IDW = 2, LAT = 2, LAT_MUL = 3;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [NREQ-1:0]     req_valid, req_ready, req_mode, req_cin;
  logic [NREQ*DW-1:0]  req_opa, req_opb;
  logic [NREQ*CW-1:0]  req_cmd;
  logic [1:0]          alu_inp_valid;
  logic [DW-1:0]       alu_opa, alu_opb;
  logic [CW-1:0]       alu_cmd;
  logic                alu_mode, alu_cin, alu_ce;
  logic [2*DW-1:0]     alu_res;
  logic                alu_cout, alu_oflow, alu_g, alu_e, alu_l, alu_err;
  logic                rsp_valid, rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [2*DW-1:0]     rsp_res;
  logic [5:0]          rsp_flags;
  logic                busy;

  logic [DW-1:0] opa [NREQ];
  logic [DW-1:0] opb [NREQ];
  logic [CW-1:0] cmd [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_opa[g*DW +: DW] = opa[g];
    assign req_opb[g*DW +: DW] = opb[g];
    assign req_cmd[g*CW +: CW] = cmd[g];
  end

  alu_req_sched #(
    .DW(DW), .CW(CW), .NREQ(NREQ), .IDW(IDW), .LAT(LAT), .LAT_MUL(LAT_MUL)
  ) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
    .req_mode(req_mode), .req_cin(req_cin),
    .alu_inp_valid(alu_inp_valid), .alu_opa(alu_opa), .alu_opb(alu_opb),
    .alu_cmd(alu_cmd), .alu_mode(alu_mode), .alu_cin(alu_cin), .alu_ce(alu_ce),
    .alu_res(alu_res), .alu_cout(alu_cout), .alu_oflow(alu_oflow),
    .alu_g(alu_g), .alu_e(alu_e), .alu_l(alu_l), .alu_err(alu_err),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_res(rsp_res), .rsp_flags(rsp_flags), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference ALU behaviour; flags packed {err, l, e, g, oflow, cout}
  typedef struct packed {
    logic [15:0] res;
    logic [5:0]  flg;
  } alu_out_t;

  function automatic alu_out_t alu_fn(input logic mode, input logic [3:0] c,
                                      input logic [7:0] a, input logic [7:0] b);
    alu_out_t   o;
    logic [8:0] s;
    o = '0;
    s = {1'b0, a} + {1'b0, b};
    if (mode) begin
      case (c)
        4'h0: begin o.res = {7'b0, s}; o.flg[0] = s[8]; end
        4'h8: begin o.flg[4] = (a < b); o.flg[3] = (a == b); o.flg[2] = (a > b); end
        4'h9: o.res = ({8'b0, a} + 16'd1) * ({8'b0, b} + 16'd1);
        default: ;
      endcase
    end else begin
      if (c == 4'h0) o.res = {8'b0, a & b};
    end
    return o;
  endfunction

  function automatic int lat_of(input logic mode, input logic [3:0] c);
    return (mode && (c == 4'h9 || c == 4'hA)) ? int'(LAT_MUL) : int'(LAT);
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < int'(NREQ); k++)
      if (v[(p + k) % int'(NREQ)]) return (p + k) % int'(NREQ);
    return 0;
  endfunction

  // Stand-in ALU: shows garbage until the cycle before the correct capture edge.
  alu_out_t f_out;
  int       f_rem;
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      f_rem <= 0;
      f_out <= '0;
    end else if (alu_ce) begin
      if (alu_inp_valid == 2'b11) begin
        f_out <= alu_fn(alu_mode, alu_cmd, alu_opa, alu_opb);
        f_rem <= lat_of(alu_mode, alu_cmd);
      end else if (f_rem > 0) begin
        f_rem <= f_rem - 1;
      end
    end
  end
  assign alu_res   = (f_rem == 1) ? f_out.res    : 16'hA5A5;
  assign alu_cout  = (f_rem == 1) ? f_out.flg[0] : 1'b1;
  assign alu_oflow = (f_rem == 1) ? f_out.flg[1] : 1'b0;
  assign alu_g     = (f_rem == 1) ? f_out.flg[2] : 1'b1;
  assign alu_e     = (f_rem == 1) ? f_out.flg[3] : 1'b0;
  assign alu_l     = (f_rem == 1) ? f_out.flg[4] : 1'b1;
  assign alu_err   = (f_rem == 1) ? f_out.flg[5] : 1'b0;

  // Transaction model: grant cycle, latency and expected response per transaction.
  int       ec = 0, g_ec = 0, m_lat = 0, m_ptr = 0, m_id = 0;
  bit       m_busy = 1'b0;
  logic [7:0] m_a, m_b;
  logic [3:0] m_cmd;
  logic       m_mode, m_cin;
  alu_out_t   m_exp;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy <= 1'b0;
      m_ptr  <= 0;
      ec     <= 0;
      g_ec   <= 0;
    end else begin
      ec <= ec + 1;
      if (!m_busy) begin
        if (req_valid != '0) begin
          m_busy <= 1'b1;
          g_ec   <= ec + 1;
          m_id   <= rr_pick(req_valid, m_ptr);
          m_ptr  <= (rr_pick(req_valid, m_ptr) + 1) % int'(NREQ);
          m_a    <= opa[rr_pick(req_valid, m_ptr)];
          m_b    <= opb[rr_pick(req_valid, m_ptr)];
          m_cmd  <= cmd[rr_pick(req_valid, m_ptr)];
          m_mode <= req_mode[rr_pick(req_valid, m_ptr)];
          m_cin  <= req_cin[rr_pick(req_valid, m_ptr)];
          m_lat  <= lat_of(req_mode[rr_pick(req_valid, m_ptr)], cmd[rr_pick(req_valid, m_ptr)]);
          m_exp  <= alu_fn(req_mode[rr_pick(req_valid, m_ptr)], cmd[rr_pick(req_valid, m_ptr)],
                           opa[rr_pick(req_valid, m_ptr)], opb[rr_pick(req_valid, m_ptr)]);
        end
      end else if ((ec - g_ec) > m_lat && rsp_ready) begin
        m_busy <= 1'b0;
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST) begin
      chk("reset_ctrl", 64'({req_ready, alu_inp_valid, alu_ce, rsp_valid, busy}), 64'd0);
      chk("reset_rsp", 64'({rsp_id, rsp_res, rsp_flags}), 64'd0);
      chk("reset_drive", 64'({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}), 64'd0);
    end else begin
      chk("req_ready", 64'(req_ready),
          (!m_busy && req_valid != '0) ? (64'd1 << rr_pick(req_valid, m_ptr)) : 64'd0);
      chk("busy", 64'(busy), 64'(m_busy));
      chk("alu_inp_valid", 64'(alu_inp_valid), (m_busy && ec == g_ec) ? 64'd3 : 64'd0);
      chk("alu_ce", 64'(alu_ce), 64'(m_busy && (ec - g_ec) <= m_lat));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_busy && (ec - g_ec) > m_lat));
      if (m_busy && ec == g_ec)
        chk("alu_drive", 64'({alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin}),
            64'({m_a, m_b, m_cmd, m_mode, m_cin}));
      if (m_busy && (ec - g_ec) > m_lat) begin
        chk("rsp_id", 64'(rsp_id), 64'(m_id));
        chk("rsp_res", 64'(rsp_res), 64'(m_exp.res));
        chk("rsp_flags", 64'(rsp_flags), 64'(m_exp.flg));
      end
    end
  end

  task automatic set_req(input int i, input logic mode, input logic [3:0] c,
                         input logic [7:0] a, input logic [7:0] b, input logic ci);
    req_mode[i] = mode;
    cmd[i]      = c;
    opa[i]      = a;
    opb[i]      = b;
    req_cin[i]  = ci;
  endtask

  // Raise the given valids, drop them after the grant edge, stop at rsp_valid.
  task automatic run_txn(input logic [NREQ-1:0] m, output int n);
    req_valid = m;
    n = 0;
    do begin
      @(posedge CLK); #1;
      n++;
      if (n == 1) req_valid = '0;
    end while (!rsp_valid && n < 40);
    chk("rsp_arrived", 64'(rsp_valid), 64'd1);
  endtask

  task automatic pulse_reset();
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b1;
  endtask

  int         n, saw, got;
  logic [1:0] ids [5];
  logic [15:0] rr_res [5];

  initial begin
    req_valid = '0;
    req_mode  = '0;
    req_cin   = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK); #1;

    // Abort in WAIT: no response afterwards
    set_req(0, 1'b1, 4'h0, 8'h10, 8'h20, 1'b0);
    req_valid = 4'b0001;
    @(posedge CLK); #1 req_valid = '0;
    @(posedge CLK); #1;
    chk("issued_then_wait", 64'({busy, alu_ce, alu_inp_valid}), 64'({1'b1, 1'b1, 2'b00}));
    RST = 1'b0;
    #1 chk("abort_outputs", 64'({busy, rsp_valid, alu_ce}), 64'd0);
    @(negedge CLK);
    @(posedge CLK); #1 RST = 1'b1;
    saw = 0;
    repeat (6) begin
      @(negedge CLK);
      if (rsp_valid) saw = 1;
    end
    chk("no_rsp_after_abort", 64'(saw), 64'd0);

    // Pointer back at 0: req0 wins over req2
    set_req(2, 1'b0, 4'h0, 8'h0F, 8'hFF, 1'b0);
    @(posedge CLK); #1;
    run_txn(4'b0101, n);
    chk("post_reset_id", 64'(rsp_id), 64'd0);
    chk("post_reset_res", 64'(rsp_res), 64'h0030);
    @(posedge CLK); #1;

    // Single add with carry out
    set_req(1, 1'b1, 4'h0, 8'hFF, 8'h01, 1'b0);
    run_txn(4'b0010, n);
    chk("add_id", 64'(rsp_id), 64'd1);
    chk("add_res", 64'(rsp_res), 64'h0100);
    chk("add_flags", 64'(rsp_flags), 64'b000001);
    chk("add_latency", 64'(n), 64'(LAT + 2));
    @(posedge CLK); #1;

    // Compare 5 vs 9: only l set
    set_req(2, 1'b1, 4'h8, 8'd5, 8'd9, 1'b1);
    run_txn(4'b0100, n);
    chk("cmp_res", 64'(rsp_res), 64'd0);
    chk("cmp_flags", 64'(rsp_flags), 64'b010000);
    chk("cmp_latency", 64'(n), 64'(LAT + 2));
    @(posedge CLK); #1;

    // Multiply (3+1)*(4+1) with the longer latency
    set_req(0, 1'b1, 4'h9, 8'd3, 8'd4, 1'b0);
    run_txn(4'b0001, n);
    chk("mul_res", 64'(rsp_res), 64'd20);
    chk("mul_latency", 64'(n), 64'(LAT_MUL + 2));
    @(posedge CLK); #1;

    // Undefined arithmetic command returns zeros
    set_req(3, 1'b1, 4'hF, 8'd7, 8'd9, 1'b0);
    run_txn(4'b1000, n);
    chk("undef_res_flags", 64'({rsp_res, rsp_flags}), 64'd0);
    chk("undef_latency", 64'(n), 64'(LAT + 2));
    @(posedge CLK); #1;

    // Backpressure: response held, no grants while another requester waits
    rsp_ready = 1'b0;
    set_req(3, 1'b0, 4'h0, 8'hF0, 8'h3C, 1'b0);
    set_req(1, 1'b1, 4'h0, 8'd1, 8'd2, 1'b0);
    run_txn(4'b1000, n);
    req_valid = 4'b0010;
    repeat (10) begin
      @(posedge CLK); #1;
      chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_res, rsp_flags, alu_ce, req_ready}),
          64'({1'b1, 2'd3, 16'h0030, 6'd0, 1'b0, 4'b0000}));
    end
    rsp_ready = 1'b1;
    @(posedge CLK); #1;
    chk("bp_release", 64'({busy, rsp_valid, req_ready}), 64'({1'b0, 1'b0, 4'b0010}));
    @(posedge CLK); #1 req_valid = '0;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("bp_next", 64'({rsp_valid, rsp_id, rsp_res}), 64'({1'b1, 2'd1, 16'h0003}));
    @(posedge CLK); #1;

    // Round robin with everyone valid
    pulse_reset();
    for (int i = 0; i < int'(NREQ); i++) set_req(i, 1'b1, 4'h0, 8'(8'h10 * (i + 1)), 8'h01, 1'b0);
    req_valid = 4'b1111;
    got = 0;
    n = 0;
    while (got < 5 && n < 100) begin
      @(posedge CLK); #1;
      n++;
      if (rsp_valid) begin
        ids[got]    = rsp_id;
        rr_res[got] = rsp_res;
        got++;
      end
    end
    req_valid = '0;
    chk("rr_count", 64'(got), 64'd5);
    chk("rr_ids", 64'({ids[0], ids[1], ids[2], ids[3], ids[4]}),
        64'({2'd0, 2'd1, 2'd2, 2'd3, 2'd0}));
    chk("rr_res", 64'({rr_res[0], rr_res[1], rr_res[2], rr_res[3]}),
        64'h0011_0021_0031_0041);
    n = 0;
    while (busy && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("drained", 64'(busy), 64'd0);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
